// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes, FSM states
// and default datapath widths.
package writeback_unit_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/writeback_unit_load_extend.sv
// Load lane select and sign/zero extension of a raw aligned memory word.
// Halfword lane uses only addr_lo[1]; unknown funct3 codes pass the word through.
module load_extend
    import writeback_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            LB:      o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            LH:      o_data = {{(XLEN-16){w_half[15]}}, w_half};
            LBU:     o_data = {{(XLEN-8){1'b0}}, w_byte};
            LHU:     o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage driving the register file write port: merges buffered ALU
// results with a single outstanding load while preserving per-register order.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int ALU_FIFO_DEPTH = 2,
    parameter int XLEN           = XLEN_DEF,
    parameter int REG_AW         = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_addr_lo,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              ld_pending,
    output logic [REG_AW-1:0] ld_pending_rd,
    output logic              we,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   rd_data
);

    // Valid/ready: a transfer happens on a cycle where both are high at the
    // clock edge; ready never depends combinationally on the matching valid.
    localparam int PW = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(ALU_FIFO_DEPTH) + 1;

    wb_state_e         r_state, w_next_state;
    logic [REG_AW-1:0] r_ld_rd;
    logic [2:0]        r_ld_funct3;
    logic [1:0]        r_ld_addr_lo;

    logic [REG_AW-1:0] r_fifo_rd   [ALU_FIFO_DEPTH];
    logic [XLEN-1:0]   r_fifo_data [ALU_FIFO_DEPTH];
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;

    logic              r_we;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_rd_data;

    logic              w_alu_fire, w_ld_fire, w_ld_ret, w_fifo_empty;
    logic              w_head_avail, w_head_held, w_alu_wr, w_bypass, w_push, w_pop;
    logic [REG_AW-1:0] w_head_rd;
    logic [XLEN-1:0]   w_head_data, w_ld_data;

    assign alu_ready     = (r_count != CW'(ALU_FIFO_DEPTH));
    assign ld_pending    = (r_state == LOAD_WAIT);
    assign ld_pending_rd = r_ld_rd;
    assign we            = r_we;
    assign rd            = r_rd;
    assign rd_data       = r_rd_data;

    assign w_alu_fire   = alu_valid & alu_ready;
    assign w_ld_fire    = ld_req_valid & ld_req_ready;
    assign w_ld_ret     = ld_pending & mem_rvalid;
    assign w_fifo_empty = (r_count == '0);

    // An empty buffer lets the incoming result act as the head (bypass).
    assign w_head_rd    = w_fifo_empty ? alu_rd   : r_fifo_rd[r_rptr];
    assign w_head_data  = w_fifo_empty ? alu_data : r_fifo_data[r_rptr];
    assign w_head_avail = ~w_fifo_empty | w_alu_fire;
    assign w_head_held  = ld_pending & (w_head_rd == r_ld_rd);
    assign w_alu_wr     = w_head_avail & ~w_head_held & ~w_ld_ret;
    assign w_bypass     = w_fifo_empty & w_alu_wr;
    assign w_push       = w_alu_fire & ~w_bypass;
    assign w_pop        = w_alu_wr & ~w_fifo_empty;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .i_funct3  (r_ld_funct3),
        .i_addr_lo (r_ld_addr_lo),
        .i_rdata   (mem_rdata),
        .o_data    (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        ld_req_ready = 1'b0;
        case (r_state)
            IDLE: begin
                ld_req_ready = 1'b1;
                if (ld_req_valid) w_next_state = LOAD_WAIT;
            end
            LOAD_WAIT: begin
                if (mem_rvalid) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= alu_rd;
            r_fifo_data[r_wptr] <= alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ld_rd      <= '0;
            r_ld_funct3  <= '0;
            r_ld_addr_lo <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_we         <= 1'b0;
            r_rd         <= '0;
            r_rd_data    <= '0;
        end else begin
            if (w_ld_fire) begin
                r_ld_rd      <= ld_rd;
                r_ld_funct3  <= ld_funct3;
                r_ld_addr_lo <= ld_addr_lo;
            end
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            // Writes to x0 still retire their source but never assert we.
            r_we <= 1'b0;
            if (w_ld_ret) begin
                r_we      <= (r_ld_rd != '0);
                r_rd      <= r_ld_rd;
                r_rd_data <= w_ld_data;
            end else if (w_alu_wr) begin
                r_we      <= (w_head_rd != '0);
                r_rd      <= w_head_rd;
                r_rd_data <= w_head_data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic compared
// each cycle against a queue-based model of the writeback ordering rules.
module tb_writeback_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_req_valid;
    logic        ld_req_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ld_pending;
    logic [4:0]  ld_pending_rd;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] rd_data;

    int n_checks = 0;
    int n_fails  = 0;

    // Model state: ALU results waiting to retire, each packed as {rd, data}.
    logic [36:0] alu_q[$];
    bit          m_pending;
    logic [4:0]  m_prd;
    logic [2:0]  m_f3;
    logic [1:0]  m_addr;
    bit          exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    writeback_unit #(.ALU_FIFO_DEPTH(DEPTH), .XLEN(32), .REG_AW(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .ld_req_valid  (ld_req_valid),
        .ld_req_ready  (ld_req_ready),
        .ld_rd         (ld_rd),
        .ld_funct3     (ld_funct3),
        .ld_addr_lo    (ld_addr_lo),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .ld_pending    (ld_pending),
        .ld_pending_rd (ld_pending_rd),
        .we            (we),
        .rd            (rd),
        .rd_data       (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext_ref(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic idle_inputs();
        alu_valid    = 1'b0;
        alu_rd       = '0;
        alu_data     = '0;
        ld_req_valid = 1'b0;
        ld_rd        = '0;
        ld_funct3    = '0;
        ld_addr_lo   = '0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
    endtask

    // Apply the model at the clock edge, check the registered outputs just
    // after it, then return inputs to idle for the caller to set again.
    task automatic step();
        bit          issue;
        logic [36:0] e;
        @(posedge clk);
        if (!rst_n) begin
            alu_q.delete();
            m_pending = 1'b0;
            exp_we    = 1'b0;
        end else begin
            issue  = !m_pending && ld_req_valid;
            exp_we = 1'b0;
            if (alu_valid && alu_q.size() < DEPTH) alu_q.push_back({alu_rd, alu_data});
            if (m_pending && mem_rvalid) begin
                exp_we    = (m_prd != 0);
                exp_rd    = m_prd;
                exp_data  = ext_ref(m_f3, m_addr, mem_rdata);
                m_pending = 1'b0;
            end else if (alu_q.size() > 0 && !(m_pending && alu_q[0][36:32] == m_prd)) begin
                e        = alu_q.pop_front();
                exp_we   = (e[36:32] != 0);
                exp_rd   = e[36:32];
                exp_data = e[31:0];
            end
            if (issue) begin
                m_pending = 1'b1;
                m_prd     = ld_rd;
                m_f3      = ld_funct3;
                m_addr    = ld_addr_lo;
            end
        end
        #1;
        check("we", {31'd0, we}, {31'd0, exp_we});
        if (exp_we) begin
            check("rd", {27'd0, rd}, {27'd0, exp_rd});
            check("rd_data", rd_data, exp_data);
        end
        check("ld_pending", {31'd0, ld_pending}, {31'd0, m_pending});
        if (m_pending) check("ld_pending_rd", {27'd0, ld_pending_rd}, {27'd0, m_prd});
        check("alu_ready", {31'd0, alu_ready}, {31'd0, (alu_q.size() < DEPTH)});
        check("ld_req_ready", {31'd0, ld_req_ready}, {31'd0, !m_pending});
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n     = 1'b0;
        m_pending = 1'b0;
        repeat (3) step();
        check("reset_we", {31'd0, we}, 32'd0);
        check("reset_rd", {27'd0, rd}, 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_ld_pending_rd", {27'd0, ld_pending_rd}, 32'd0);
        rst_n = 1'b1;
        step();

        // ALU result with an empty buffer retires the next cycle.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234;
        step();
        check("alu_bypass_rd", {27'd0, rd}, 32'd3);
        check("alu_bypass_data", rd_data, 32'h0000_1234);
        step();

        // Sign-extended byte load from lane 2.
        ld_req_valid = 1'b1; ld_rd = 5'd5; ld_funct3 = 3'b000; ld_addr_lo = 2'd2;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h0080_0000;
        step();
        check("lb_we", {31'd0, we}, 32'd1);
        check("lb_data", rd_data, 32'hFFFF_FF80);
        check("lb_pending_clear", {31'd0, ld_pending}, 32'd0);

        // Load return coincident with an ALU result: load first.
        ld_req_valid = 1'b1; ld_rd = 5'd7; ld_funct3 = 3'b101; ld_addr_lo = 2'd2;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0000;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'd9;
        step();
        check("lhu_first_rd", {27'd0, rd}, 32'd7);
        check("lhu_first_data", rd_data, 32'h0000_BEEF);
        step();
        check("alu_second_rd", {27'd0, rd}, 32'd4);
        check("alu_second_data", rd_data, 32'd9);

        // WAW hold: results behind a pending load to the same register wait.
        ld_req_valid = 1'b1; ld_rd = 5'd6; ld_funct3 = 3'b010;
        step();
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'd1;
        step();
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'd2;
        step();
        check("held_full_ready", {31'd0, alu_ready}, 32'd0);
        step();
        check("held_no_write", {31'd0, we}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        check("waw_load_data", rd_data, 32'hCAFE_F00D);
        step();
        check("waw_alu6", rd_data, 32'd1);
        step();
        check("waw_alu2", rd_data, 32'd2);

        // Writes to x0 are consumed without asserting we.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
        step();
        check("x0_alu_we", {31'd0, we}, 32'd0);
        ld_req_valid = 1'b1; ld_rd = 5'd0; ld_funct3 = 3'b010;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        check("x0_load_we", {31'd0, we}, 32'd0);
        check("x0_load_pending", {31'd0, ld_pending}, 32'd0);

        // Reset during LOAD_WAIT drops the load; a late return is ignored.
        ld_req_valid = 1'b1; ld_rd = 5'd9; ld_funct3 = 3'b010;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        check("rst_load_we", {31'd0, we}, 32'd0);
        check("rst_load_pending", {31'd0, ld_pending}, 32'd0);
        check("rst_load_req_ready", {31'd0, ld_req_ready}, 32'd1);

        // Random traffic with a small register range to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 299) != 0);
            alu_valid    = ($urandom_range(0, 9) < 6);
            alu_rd       = 5'($urandom_range(0, 7));
            alu_data     = $urandom;
            ld_req_valid = ($urandom_range(0, 9) < 3);
            ld_rd        = 5'($urandom_range(0, 7));
            ld_funct3    = 3'($urandom_range(0, 7));
            ld_addr_lo   = 2'($urandom_range(0, 3));
            mem_rvalid   = ($urandom_range(0, 9) < 3);
            mem_rdata    = $urandom;
            step();
        end
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
